// File: rtl/test_pkg.sv
// Shared definitions for the array packer: default element width, element word type
// and the two-state frame FSM encoding.
package test_pkg;

    localparam int FOO_DEFAULT = 4;

    typedef logic signed [FOO_DEFAULT-1:0] elem_t;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/test_idx_counter.sv
// Write-index counter for the packer: counts accepted words 0..FOO-1 within a frame
// and flags the last slot.
module test_idx_counter
    import test_pkg::*;
#(
    parameter int FOO   = FOO_DEFAULT,
    parameter int IDX_W = $clog2(FOO)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [IDX_W-1:0] idx,
    output logic             last
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (inc) begin
            idx <= idx + 1'b1;
        end
    end

    assign last = (idx == IDX_W'(FOO - 1));

endmodule

// File: rtl/test_array_packer.sv
// Packs a serial stream of FOO-bit signed words into one FOO-element array frame,
// with early-termination flag and element count, held until the consumer accepts it.
module test_array_packer
    import test_pkg::*;
#(
    parameter int FOO = FOO_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [FOO-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_a,
    output logic [31:0]           out_b,
    output logic signed [FOO-1:0] out_c [FOO]
);

    localparam int IDX_W = $clog2(FOO);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx;
    logic             idx_last;
    logic             in_acc, out_acc, close;

    assign in_acc  = in_valid && in_ready;
    assign out_acc = out_valid && out_ready;
    assign close   = in_acc && (idx_last || in_last);

    test_idx_counter #(
        .FOO   (FOO),
        .IDX_W (IDX_W)
    ) u_idx (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (close),
        .inc   (in_acc && !close),
        .idx   (idx),
        .last  (idx_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // A frame released while a word is accepted restarts FILL, or goes straight back to HOLD
    // when that word alone closes the next frame.
    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (close)   state_nxt = HOLD;
            HOLD:    if (out_acc) state_nxt = close ? HOLD : FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_comb begin
        out_valid = (state == HOLD);
        in_ready  = !out_valid || out_ready;
    end

    // The first word of a frame clears the tail so short frames never show stale elements.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < FOO; i++) begin
                out_c[i] <= '0;
            end
            out_a <= 1'b0;
            out_b <= '0;
        end else if (in_acc) begin
            if (idx == '0) begin
                for (int i = 1; i < FOO; i++) begin
                    out_c[i] <= '0;
                end
            end
            out_c[idx] <= in_data;
            if (close) begin
                out_b <= 32'(idx) + 32'd1;
                out_a <= in_last && !idx_last;
            end
        end
    end

endmodule
